// File: rtl/inst_decode_reg.sv
// rtl/inst_decode_reg.sv - decode-stage register with skid buffer between fetch and execute
// Instructions are decoded on entry and held in a two-deep (main + skid) in-order buffer.
module inst_decode_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [24:0] out_imm,
  output logic [2:0]  out_inst_type,
  output logic        out_shift_imm,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic        out_illegal
);

  // Instruction-format encodings shared with the rest of the core
  localparam logic [2:0] INST_R    = 3'd0;
  localparam logic [2:0] INST_I    = 3'd1;
  localparam logic [2:0] INST_S    = 3'd2;
  localparam logic [2:0] INST_B    = 3'd3;
  localparam logic [2:0] INST_U    = 3'd4;
  localparam logic [2:0] INST_J    = 3'd5;
  localparam logic [2:0] INST_NONE = 3'b111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  inst_type;
    logic        shift_imm;
    logic        illegal;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  entry_t in_dec;
  logic   accept;
  logic   consume;

  always_comb begin
    in_dec           = '0;
    in_dec.pc        = in_pc;
    in_dec.inst      = in_inst;
    in_dec.inst_type = INST_NONE;
    in_dec.shift_imm = 1'b0;
    in_dec.illegal   = 1'b0;
    case (in_inst[6:0])
      7'b0110011: in_dec.inst_type = INST_R;
      7'b0010011: begin
        in_dec.inst_type = INST_I;
        in_dec.shift_imm = (in_inst[14:12] == 3'b001) || (in_inst[14:12] == 3'b101);
      end
      7'b0000011, 7'b1100111, 7'b1110011: in_dec.inst_type = INST_I;
      7'b0100011: in_dec.inst_type = INST_S;
      7'b1100011: in_dec.inst_type = INST_B;
      7'b0110111, 7'b0010111: in_dec.inst_type = INST_U;
      7'b1101111: in_dec.inst_type = INST_J;
      default: in_dec.illegal = 1'b1;
    endcase
  end

  // in_ready depends only on the state flops, never on out_ready
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= EMPTY;
      main_q.pc        <= '0;
      main_q.inst      <= '0;
      main_q.inst_type <= INST_NONE;
      main_q.shift_imm <= 1'b0;
      main_q.illegal   <= 1'b0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= in_dec;
            state  <= ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_q <= in_dec;
          end else if (accept) begin
            skid_q <= in_dec;
            state  <= FULL;
          end else if (consume) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          // skid is always the younger entry, so it simply advances into main
          if (consume) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_pc        = main_q.pc;
  assign out_inst      = main_q.inst;
  assign out_imm       = main_q.inst[31:7];
  assign out_inst_type = main_q.inst_type;
  assign out_shift_imm = main_q.shift_imm;
  assign out_illegal   = main_q.illegal;
  assign out_rd        = main_q.inst[11:7];
  assign out_rs1       = main_q.inst[19:15];
  assign out_rs2       = main_q.inst[24:20];

endmodule

// File: tb/tb_inst_decode_reg.sv
// tb/tb_inst_decode_reg.sv - self-checking bench for inst_decode_reg
// A two-slot FIFO model tracks held instructions; the head is what execute should see.
module tb_inst_decode_reg;

  localparam logic [2:0] INST_R    = 3'd0;
  localparam logic [2:0] INST_I    = 3'd1;
  localparam logic [2:0] INST_S    = 3'd2;
  localparam logic [2:0] INST_B    = 3'd3;
  localparam logic [2:0] INST_U    = 3'd4;
  localparam logic [2:0] INST_J    = 3'd5;
  localparam logic [2:0] INST_NONE = 3'b111;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_pc, in_inst;
  logic [31:0] out_pc, out_inst;
  logic [24:0] out_imm;
  logic [2:0]  out_inst_type;
  logic        out_shift_imm, out_illegal;
  logic [4:0]  out_rd, out_rs1, out_rs2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  typ;
    logic        shift;
    logic        ill;
  } item_t;

  item_t q[$];
  item_t head;
  logic [6:0] ops [10];

  inst_decode_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_imm(out_imm),
    .out_inst_type(out_inst_type), .out_shift_imm(out_shift_imm),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  function automatic item_t ref_item(input logic [31:0] pc, input logic [31:0] inst);
    item_t it;
    logic [6:0] op;
    logic [2:0] f3;
    op       = inst[6:0];
    f3       = inst[14:12];
    it.pc    = pc;
    it.inst  = inst;
    it.shift = 1'b0;
    it.ill   = 1'b0;
    if (op == 7'h33)                                         it.typ = INST_R;
    else if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73) it.typ = INST_I;
    else if (op == 7'h23)                                    it.typ = INST_S;
    else if (op == 7'h63)                                    it.typ = INST_B;
    else if (op == 7'h37 || op == 7'h17)                     it.typ = INST_U;
    else if (op == 7'h6F)                                    it.typ = INST_J;
    else begin
      it.typ = INST_NONE;
      it.ill = 1'b1;
    end
    if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) it.shift = 1'b1;
    return it;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    if (q.size() > 0) head = q[0];
    chk({tag, ":out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, ":in_ready"},  32'(in_ready),  32'(q.size() < 2));
    chk({tag, ":out_pc"},    out_pc,   head.pc);
    chk({tag, ":out_inst"},  out_inst, head.inst);
    chk({tag, ":out_imm"},   32'(out_imm), 32'(head.inst >> 7));
    chk({tag, ":type"},      32'(out_inst_type), 32'(head.typ));
    chk({tag, ":shift"},     32'(out_shift_imm), 32'(head.shift));
    chk({tag, ":illegal"},   32'(out_illegal),   32'(head.ill));
    chk({tag, ":regs"}, {17'd0, out_rd, out_rs1, out_rs2},
        {17'd0, head.inst[11:7], head.inst[19:15], head.inst[24:20]});
  endtask

  // One clock: drive inputs, advance the model at the edge, then compare.
  task automatic cycle(input string tag, input logic v, input logic [31:0] pc,
                       input logic [31:0] inst, input logic ordy,
                       input logic fl, input logic r);
    logic acc, cons;
    rst = r; flush = fl; in_valid = v; in_pc = pc; in_inst = inst; out_ready = ordy;
    acc  = v && (q.size() < 2);
    cons = ordy && (q.size() > 0);
    @(posedge clk);
    if (r) begin
      q.delete();
      head = '{pc: 32'd0, inst: 32'd0, typ: INST_NONE, shift: 1'b0, ill: 1'b0};
    end else if (fl) begin
      q.delete();
    end else begin
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(ref_item(pc, inst));
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    head = '{pc: 32'd0, inst: 32'd0, typ: INST_NONE, shift: 1'b0, ill: 1'b0};
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    #1;

    cycle("reset0", 1, 32'h10, 32'h00500093, 1, 0, 1);
    cycle("reset1", 0, 32'h0, 32'h0, 0, 0, 1);
    chk("reset_type_none", 32'(out_inst_type), 32'(INST_NONE));

    cycle("addi", 1, 32'h100, 32'h00500093, 1, 0, 0);
    chk("addi_type", 32'(out_inst_type), 32'(INST_I));
    chk("addi_imm", 32'(out_imm), 32'h000A001);
    chk("addi_rd", 32'(out_rd), 32'd1);

    cycle("slli", 1, 32'h104, 32'h00311093, 1, 0, 0);
    chk("slli_shift", 32'(out_shift_imm), 32'd1);
    chk("slli_rs1", 32'(out_rs1), 32'd2);
    cycle("drain0", 0, 32'h0, 32'h0, 1, 0, 0);

    // back-pressure: A and B held, then drained in order
    cycle("bp_a", 1, 32'h200, 32'h002081B3, 0, 0, 0);
    cycle("bp_b", 1, 32'h204, 32'h00C0006F, 0, 0, 0);
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    cycle("bp_hold", 1, 32'h208, 32'h00000013, 0, 0, 0);
    chk("bp_hold_pc", out_pc, 32'h200);
    cycle("bp_pop_a", 0, 32'h0, 32'h0, 1, 0, 0);
    chk("bp_b_pc", out_pc, 32'h204);
    cycle("bp_pop_b", 0, 32'h0, 32'h0, 1, 0, 0);

    // flush while full with a pending input
    cycle("fl_a", 1, 32'h300, 32'h00112023, 0, 0, 0);
    cycle("fl_b", 1, 32'h304, 32'h00208463, 0, 0, 0);
    cycle("flush", 1, 32'h308, 32'h123450B7, 0, 1, 0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    cycle("post_flush", 0, 32'h0, 32'h0, 1, 0, 0);
    // flush from ONE with an accept in the same cycle drops the input
    cycle("fl1_a", 1, 32'h310, 32'h00000017, 0, 0, 0);
    cycle("fl1_flush", 1, 32'h314, 32'h00000013, 1, 1, 0);

    cycle("illegal", 1, 32'h400, 32'h0000007F, 1, 0, 0);
    chk("illegal_flag", 32'(out_illegal), 32'd1);
    chk("illegal_type", 32'(out_inst_type), 32'(INST_NONE));

    // reset mid-stream from FULL
    cycle("rs_a", 1, 32'h500, 32'h00500093, 0, 0, 0);
    cycle("rs_b", 1, 32'h504, 32'h00311093, 0, 0, 0);
    cycle("rs_hit", 1, 32'h508, 32'h00000033, 1, 0, 1);
    chk("rs_type", 32'(out_inst_type), 32'(INST_NONE));
    cycle("rs_after", 0, 32'h0, 32'h0, 1, 0, 0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] inst;
      int sel;
      inst = $urandom;
      sel = $urandom_range(0, 10);
      if (sel < 10) inst[6:0] = ops[sel];
      cycle("rand", ($urandom_range(0, 9) < 7), $urandom, inst,
            ($urandom_range(0, 9) < 5), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 99) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
